mem_result_display: RTL and testbench
=====================================

# mem_result_display

Post-execution result viewer between the pipelined CPU's data memory and the `scan_output` 7-segment driver. On `start`, which is asserted once the CPU has finished executing, the block walks a window of data-memory words. For each word it issues a read, latches the returned word and presents its low 16 bits as four hex digits. It holds each word on the display for a programmable dwell time, then advances to the next word. It replaces free-running address stepping with a deterministic, pausable sequencer.

## Interface
- `START_ADDR`, 32'h0000_0004, byte address of first word shown
- `WORD_COUNT`, 16, number of words shown (1..256)
- `DWELL_CYCLES`, 100_000_000, clk cycles each word stays on display (>=1)
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `start`  in  1  level-sampled; begins a walk when sampled high in IDLE or DONE
- `hold`  in  1  freezes dwell counter while high
- `mem_rdata`  in  32  read data from DataMemory
- `mem_read`  out  1  read enable to DataMemory
- `mem_addr`  out  32  byte address to DataMemory
- `count_1`, `count_2`, `count_3`, `count_4`  out  4 each  digits = latched word [15:12], [11:8], [7:4], [3:0]
- `word_index`  out  8  index of word currently displayed
- `busy`  out  1  high in ISSUE/CAPTURE/SHOW
- `done`  out  1  high in DONE

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, SHOW, DONE.
- IDLE: `start` high at an edge -> ISSUE. `mem_addr` is loaded with START_ADDR and `word_index` is set to 0.
- ISSUE, one cycle: `mem_read`=1 and `mem_addr` stable -> CAPTURE.
- CAPTURE, one cycle: `mem_read`=1 and `mem_addr` unchanged. At the closing edge the block latches `mem_rdata` into the display word, clears the dwell counter and moves to SHOW. This two-cycle read window suits both combinational-read and 1-cycle registered-read memories.
- SHOW: the dwell counter increments each cycle while `hold`=0 and freezes while `hold`=1. When the counter reaches DWELL_CYCLES-1 with `hold`=0:
  - if `word_index`==WORD_COUNT-1 -> DONE;
  - otherwise `word_index`+1, `mem_addr`+4 -> ISSUE.
- DONE: the last word stays on the display and `done`=1. `start` high -> restart exactly as from IDLE.
- `start` is ignored in ISSUE, CAPTURE and SHOW.
- `mem_addr` is incremented modulo 2^32 (wraps from 32'hFFFF_FFFC to 0). It holds its value outside ISSUE/CAPTURE.
- `mem_read`=0 in IDLE, SHOW and DONE.
- `count_*` change only at the CAPTURE closing edge, so the display is glitch-free between words.
- The dwell counter is wide enough for DWELL_CYCLES (32 bits).

## Timing
- Reset values: state IDLE, `mem_read`=0, `mem_addr`=START_ADDR, `count_1..4`=0, `word_index`=0, `busy`=0, `done`=0, dwell counter 0.
- Asserting `reset` mid-walk returns all of the above immediately (asynchronously). No memory read completes.
- Latency from `start` to display:
  - `start` sampled at edge E0;
  - ISSUE during E0..E1;
  - CAPTURE during E1..E2;
  - `count_*` show word 0 after E2.
- Per-word period with `hold`=0 is DWELL_CYCLES+2 cycles.
- Each `hold` cycle in SHOW extends that period by one cycle.
- `hold` has no effect in ISSUE or CAPTURE.
- DONE is entered DWELL_CYCLES cycles after the last word's CAPTURE edge. `busy` falls and `done` rises on that same edge.
- WORD_COUNT=1: a single read, then DONE after one dwell.

## Test plan
- Walk with START_ADDR=4, WORD_COUNT=3, DWELL_CYCLES=4 and memory words 0x1234, 0xABCD, 0x0F0F at addresses 4, 8, 12:
  - digits show 1,2,3,4 / A,B,C,D / 0,F,0,F;
  - each word is displayed for 6 cycles;
  - `done`=1 after the third dwell;
  - `mem_read` is high for exactly 6 cycles in total.
- `hold` high for 10 cycles mid-SHOW of word 1 -> word 1 is displayed for 16 cycles, and no `mem_addr` change occurs during the hold.
- `start` pulsed again during SHOW -> ignored. `start` in DONE -> the walk restarts at address 4 with `word_index`=0 and `done` cleared.
- `reset` low during CAPTURE of word 2 -> all outputs return to their reset values at once; after release the block stays in IDLE until `start`.
- START_ADDR=32'hFFFF_FFFC, WORD_COUNT=2 -> second read at address 0x0000_0000.
- Memory word 0xDEAD_5A5A -> digits 5,A,5,A; the upper half is ignored.

Source files
------------

// File: rtl/mem_result_display.sv
// mem_result_display: steps through a window of data-memory words after the
// CPU has finished. Each word is read, latched, and shown as four hex digits
// for a programmable dwell time. Holding the dwell counter pauses the walk.
//
// Memory read contract: mem_read is high for exactly two cycles per word
// (ISSUE then CAPTURE). mem_addr is stable across both cycles. mem_rdata is
// sampled at the closing edge of CAPTURE. A combinational-read memory and a
// memory with a one-cycle registered read are both valid at that edge.
module mem_result_display #(
  parameter logic [31:0] START_ADDR   = 32'h0000_0004,
  parameter int unsigned WORD_COUNT   = 16,
  parameter int unsigned DWELL_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hold,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [3:0]  count_1,
  output logic [3:0]  count_2,
  output logic [3:0]  count_3,
  output logic [3:0]  count_4,
  output logic [7:0]  word_index,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SHOW    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [7:0]  LAST_IDX   = 8'(WORD_COUNT - 1);
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic [31:0] dwell_q, dwell_d;
  logic        mem_read_q, mem_read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Only the low half of each word is displayed.
  logic unused_upper;
  assign unused_upper = ^mem_rdata[31:16];

  // Next-state and datapath updates for the walk sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    word_d  = word_q;
    dwell_d = dwell_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ISSUE;
          addr_d  = START_ADDR;
          idx_d   = 8'd0;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        word_d  = mem_rdata[15:0];
        dwell_d = 32'd0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (!hold) begin
          if (dwell_q == DWELL_LAST) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 8'd1;
              addr_d  = addr_q + 32'd4;
              state_d = S_ISSUE;
            end
          end else begin
            dwell_d = dwell_q + 32'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from the next state so that they are registered.
    mem_read_d = (state_d == S_ISSUE) || (state_d == S_CAPTURE);
    busy_d     = mem_read_d || (state_d == S_SHOW);
    done_d     = (state_d == S_DONE);
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= START_ADDR;
      idx_q      <= 8'd0;
      word_q     <= 16'd0;
      dwell_q    <= 32'd0;
      mem_read_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      dwell_q    <= dwell_d;
      mem_read_q <= mem_read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_read   = mem_read_q;
  assign mem_addr   = addr_q;
  assign count_1    = word_q[15:12];
  assign count_2    = word_q[11:8];
  assign count_3    = word_q[7:4];
  assign count_4    = word_q[3:0];
  assign word_index = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_result_display.sv
// Bench for mem_result_display: a 3-word walk with a short dwell (instance A)
// and a 2-word walk that wraps the address space (instance B).
module tb_mem_result_display;

  logic clk;
  logic reset;

  logic        start_a, hold_a;
  logic [31:0] rdata_a, addr_a;
  logic        mem_read_a, busy_a, done_a;
  logic [3:0]  c1_a, c2_a, c3_a, c4_a;
  logic [7:0]  idx_a;
  logic [2:0]  st_a;

  logic        start_b, hold_b;
  logic [31:0] rdata_b, addr_b;
  logic        mem_read_b, busy_b, done_b;
  logic [3:0]  c1_b, c2_b, c3_b, c4_b;
  logic [7:0]  idx_b;
  logic [2:0]  st_b;

  int errors = 0;
  int checks = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_result_display #(.START_ADDR(32'h0000_0004), .WORD_COUNT(3), .DWELL_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .hold(hold_a), .mem_rdata(rdata_a),
    .mem_read(mem_read_a), .mem_addr(addr_a), .count_1(c1_a), .count_2(c2_a),
    .count_3(c3_a), .count_4(c4_a), .word_index(idx_a), .busy(busy_a), .done(done_a),
    .dbg_state(st_a));

  mem_result_display #(.START_ADDR(32'hFFFF_FFFC), .WORD_COUNT(2), .DWELL_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .hold(hold_b), .mem_rdata(rdata_b),
    .mem_read(mem_read_b), .mem_addr(addr_b), .count_1(c1_b), .count_2(c2_b),
    .count_3(c3_b), .count_4(c4_b), .word_index(idx_b), .busy(busy_b), .done(done_b),
    .dbg_state(st_b));

  // Combinational-read data memories; upper halves carry junk that must not show.
  function automatic logic [31:0] mem_model_a(input logic [31:0] a);
    case (a)
      32'd4:   return 32'h7777_1234;
      32'd8:   return 32'h8888_ABCD;
      32'd12:  return 32'h9999_0F0F;
      default: return 32'hEEEE_EEEE;
    endcase
  endfunction

  function automatic logic [31:0] mem_model_b(input logic [31:0] a);
    case (a)
      32'hFFFF_FFFC: return 32'hDEAD_5A5A;
      32'h0000_0000: return 32'h0000_1357;
      default:       return 32'hEEEE_EEEE;
    endcase
  endfunction

  assign rdata_a = mem_model_a(addr_a);
  assign rdata_b = mem_model_b(addr_b);

  // Observed outputs of instance A: {mem_read, busy, done, word_index, mem_addr, digits}
  function automatic logic [58:0] obs_a();
    return {mem_read_a, busy_a, done_a, idx_a, addr_a, c1_a, c2_a, c3_a, c4_a};
  endfunction

  // Expected outputs of instance A k cycles after the start edge, no hold.
  // Each word takes 6 cycles: ISSUE, CAPTURE, then 4 dwell cycles.
  function automatic logic [58:0] exp_walk(input int k, input logic [15:0] prev);
    logic [15:0] w [3];
    logic [15:0] disp;
    int p;
    int r;
    w[0] = 16'h1234;
    w[1] = 16'hABCD;
    w[2] = 16'h0F0F;
    if (k >= 18) return {1'b0, 1'b0, 1'b1, 8'd2, 32'd12, 16'h0F0F};
    p = k / 6;
    r = k % 6;
    disp = (k < 2) ? prev : w[(k - 2) / 6];
    return {(r < 2), 1'b1, 1'b0, 8'(p), 32'(4 + 4 * p), disp};
  endfunction

  localparam logic [58:0] RESET_A = {1'b0, 1'b0, 1'b0, 8'd0, 32'd4, 16'h0000};

  task automatic test_reset();
    reset = 1'b0;
    start_a = 1'b0; hold_a = 1'b0;
    start_b = 1'b0; hold_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_a() !== RESET_A) begin
      errors++;
      $display("FAIL reset_a: got %h expected %h", obs_a(), RESET_A);
    end
    checks++;
    if (st_a !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", st_a);
    end
    checks++;
    if ({mem_read_b, busy_b, done_b, addr_b} !== {3'b000, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL reset_b: got %b %h expected 000 fffffffc", {mem_read_b, busy_b, done_b}, addr_b);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full 3-word walk, with a stray start pulse during SHOW of word 0.
  task automatic test_walk();
    int rd_cycles = 0;
    int w0_cycles = 0;
    start_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) start_a = 1'b0;
      checks++;
      if (obs_a() !== exp_walk(k, 16'h0000)) begin
        errors++;
        $display("FAIL walk k=%0d: got %h expected %h", k, obs_a(), exp_walk(k, 16'h0000));
      end
      if (mem_read_a) rd_cycles++;
      if ({c1_a, c2_a, c3_a, c4_a} == 16'h1234) w0_cycles++;
      if (k == 3) start_a = 1'b1;
      if (k == 4) start_a = 1'b0;
    end
    checks++;
    if (rd_cycles != 6) begin
      errors++;
      $display("FAIL walk_read_cycles: got %0d expected 6", rd_cycles);
    end
    checks++;
    if (w0_cycles != 6) begin
      errors++;
      $display("FAIL walk_word0_cycles: got %0d expected 6", w0_cycles);
    end
  endtask

  // start from DONE restarts at the first address with done cleared.
  task automatic test_restart();
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (obs_a() !== exp_walk(0, 16'h0F0F)) begin
      errors++;
      $display("FAIL restart: got %h expected %h", obs_a(), exp_walk(0, 16'h0F0F));
    end
  endtask

  // Continues the restarted walk; hold is high for 10 cycles in SHOW of word 1.
  task automatic test_hold();
    int w1_cycles = 0;
    int done_at = -1;
    int k_eff;
    logic [58:0] e;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      k_eff = (k <= 9) ? k : ((k <= 19) ? 9 : k - 10);
      e = exp_walk(k_eff, 16'h0F0F);
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL hold k=%0d: got %h expected %h", k, obs_a(), e);
      end
      if ({c1_a, c2_a, c3_a, c4_a} == 16'hABCD) w1_cycles++;
      if (done_a && done_at < 0) done_at = k;
      if (k == 9) hold_a = 1'b1;
      if (k == 19) hold_a = 1'b0;
    end
    checks++;
    if (w1_cycles != 16) begin
      errors++;
      $display("FAIL hold_word1_cycles: got %0d expected 16", w1_cycles);
    end
    checks++;
    if (done_at != 28) begin
      errors++;
      $display("FAIL hold_done_cycle: got %0d expected 28", done_at);
    end
  endtask

  // Reset asserted during CAPTURE of word 2 acts immediately.
  task automatic test_reset_mid();
    start_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k == 0) start_a = 1'b0;
      checks++;
      if (obs_a() !== exp_walk(k, 16'h0F0F)) begin
        errors++;
        $display("FAIL reset_mid_walk k=%0d: got %h expected %h", k, obs_a(), exp_walk(k, 16'h0F0F));
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs_a() !== RESET_A) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", obs_a(), RESET_A);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (obs_a() !== RESET_A || st_a !== 3'd0) begin
      errors++;
      $display("FAIL reset_stay_idle: got %h state %0d expected %h state 0", obs_a(), st_a, RESET_A);
    end
  endtask

  // Address wrap from FFFF_FFFC to 0, and upper half of a word ignored.
  task automatic test_wrap();
    start_b = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) start_b = 1'b0;
      if (k == 0) begin
        checks++;
        if (addr_b !== 32'hFFFF_FFFC || mem_read_b !== 1'b1) begin
          errors++;
          $display("FAIL wrap_first_read: got addr %h rd %b expected fffffffc 1", addr_b, mem_read_b);
        end
      end
      if (k == 2) begin
        checks++;
        if ({c1_b, c2_b, c3_b, c4_b} !== {4'h5, 4'hA, 4'h5, 4'hA}) begin
          errors++;
          $display("FAIL wrap_digits0: got %h%h%h%h expected 5a5a", c1_b, c2_b, c3_b, c4_b);
        end
      end
      if (k == 4) begin
        checks++;
        if (addr_b !== 32'h0000_0000 || idx_b !== 8'd1 || mem_read_b !== 1'b1) begin
          errors++;
          $display("FAIL wrap_second_read: got addr %h idx %0d rd %b expected 00000000 1 1", addr_b, idx_b, mem_read_b);
        end
      end
      if (k == 6) begin
        checks++;
        if ({c1_b, c2_b, c3_b, c4_b} !== 16'h1357) begin
          errors++;
          $display("FAIL wrap_digits1: got %h%h%h%h expected 1357", c1_b, c2_b, c3_b, c4_b);
        end
      end
      if (k == 8) begin
        checks++;
        if ({done_b, busy_b, mem_read_b} !== 3'b100) begin
          errors++;
          $display("FAIL wrap_done: got done %b busy %b rd %b expected 1 0 0", done_b, busy_b, mem_read_b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_restart();
    test_hold();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
